// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - note codes, duration encodings and song entry layout shared with the tone generator
package tone_pkg;

  localparam logic [2:0] NOTE_C4 = 3'd0;
  localparam logic [2:0] NOTE_D4 = 3'd1;
  localparam logic [2:0] NOTE_E4 = 3'd2;
  localparam logic [2:0] NOTE_F4 = 3'd3;
  localparam logic [2:0] NOTE_G4 = 3'd4;
  localparam logic [2:0] NOTE_A4 = 3'd5;
  localparam logic [2:0] NOTE_B4 = 3'd6;
  localparam logic [2:0] NOTE_C5 = 3'd7;

  // Duration field is log2 of the beat count.
  localparam logic [1:0] DUR_1 = 2'd0;
  localparam logic [1:0] DUR_2 = 2'd1;
  localparam logic [1:0] DUR_4 = 2'd2;
  localparam logic [1:0] DUR_8 = 2'd3;

  typedef struct packed {
    logic       rest;
    logic [2:0] note;
    logic [1:0] dur;
  } song_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  function automatic song_entry_t mk_note(input logic [2:0] note, input logic [1:0] dur);
    song_entry_t e;
    e.rest = 1'b0;
    e.note = note;
    e.dur  = dur;
    return e;
  endfunction

  // A rest keeps a note code so the frequency output stays defined.
  function automatic song_entry_t mk_rest(input logic [2:0] note, input logic [1:0] dur);
    song_entry_t e;
    e.rest = 1'b1;
    e.note = note;
    e.dur  = dur;
    return e;
  endfunction

endpackage

// File: rtl/melody_rom.sv
// rtl/melody_rom.sv - combinational 16-entry song table
module melody_rom
  import tone_pkg::*;
(
  input  logic [3:0] addr,
  output logic [5:0] entry
);

  always_comb begin
    entry = mk_note(NOTE_C4, DUR_1);
    case (addr)
      4'd0:  entry = mk_note(NOTE_C4, DUR_1);
      4'd1:  entry = mk_note(NOTE_D4, DUR_1);
      4'd2:  entry = mk_note(NOTE_E4, DUR_1);
      4'd3:  entry = mk_note(NOTE_F4, DUR_1);
      4'd4:  entry = mk_note(NOTE_G4, DUR_1);
      4'd5:  entry = mk_note(NOTE_A4, DUR_1);
      4'd6:  entry = mk_note(NOTE_B4, DUR_1);
      4'd7:  entry = mk_note(NOTE_C5, DUR_1);
      4'd8:  entry = mk_rest(NOTE_C5, DUR_2);
      4'd9:  entry = mk_note(NOTE_B4, DUR_1);
      4'd10: entry = mk_note(NOTE_A4, DUR_1);
      4'd11: entry = mk_note(NOTE_G4, DUR_1);
      4'd12: entry = mk_note(NOTE_F4, DUR_1);
      4'd13: entry = mk_note(NOTE_E4, DUR_1);
      4'd14: entry = mk_note(NOTE_D4, DUR_1);
      4'd15: entry = mk_note(NOTE_C4, DUR_1);
      default: entry = mk_note(NOTE_C4, DUR_1);
    endcase
  end

endmodule

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - steps through melody_rom driving freq/gate with an articulation gap per note
// MELODY_LOOP_EN: when defined, the song restarts at step 0 instead of stopping after the last entry.
module melody_sequencer
  import tone_pkg::*;
#(
  parameter int unsigned BEAT_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES  = 1_250_000,
  parameter int unsigned SONG_LEN    = 16
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  output logic [2:0] freq,
  output logic       gate,
  output logic       busy,
  output logic       done
);

  localparam int unsigned   CW        = $clog2(8 * BEAT_CYCLES + 1);
  localparam logic [CW-1:0] BEAT_W    = CW'(BEAT_CYCLES);
  localparam logic [CW-1:0] GAP_W     = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] ONE_W     = CW'(1);
  localparam logic [3:0]    LAST_STEP = 4'(SONG_LEN - 1);

`ifdef MELODY_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  seq_state_t    r_state, w_state;
  logic [3:0]    r_step, w_step;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [1:0]    r_dur, w_dur;
  logic [2:0]    r_freq, w_freq;
  logic          r_gate, w_gate;
  logic          r_busy, w_busy;
  logic          r_done, w_done;

  logic [3:0]    w_wrap_step;
  logic [3:0]    w_rom_addr;
  logic          w_last_step;
  song_entry_t   w_entry;
  logic [CW-1:0] w_len;
  logic [CW-1:0] w_last_cnt;
  logic [CW-1:0] w_gap_start;
  logic [CW-1:0] w_cnt_inc;

  // The ROM is always addressed with the entry that would be loaded next.
  assign w_last_step = (r_step == LAST_STEP);
  assign w_wrap_step = w_last_step ? 4'd0 : r_step + 4'd1;
  assign w_rom_addr  = (r_state == ST_IDLE) ? 4'd0 : w_wrap_step;

  melody_rom u_rom (
    .addr  (w_rom_addr),
    .entry (w_entry)
  );

  assign w_len       = BEAT_W << r_dur;
  assign w_last_cnt  = w_len - ONE_W;
  assign w_gap_start = w_len - GAP_W;
  assign w_cnt_inc   = r_cnt + ONE_W;

  always_comb begin
    w_state = r_state;
    w_step  = r_step;
    w_cnt   = r_cnt;
    w_dur   = r_dur;
    w_freq  = r_freq;
    w_gate  = r_gate;
    w_busy  = r_busy;
    w_done  = 1'b0;
    if (stop) begin
      w_state = ST_IDLE;
      w_step  = 4'd0;
      w_cnt   = '0;
      w_gate  = 1'b0;
      w_busy  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_gate = 1'b0;
          w_busy = 1'b0;
          if (start) begin
            w_state = ST_PLAY;
            w_step  = w_rom_addr;
            w_cnt   = '0;
            w_dur   = w_entry.dur;
            w_freq  = w_entry.note;
            w_gate  = ~w_entry.rest;
            w_busy  = 1'b1;
          end
        end
        ST_PLAY, ST_GAP: begin
          if (r_cnt == w_last_cnt) begin
            if (w_last_step && !LOOP_EN) begin
              w_state = ST_DONE;
              w_step  = 4'd0;
              w_cnt   = '0;
              w_gate  = 1'b0;
              w_busy  = 1'b0;
              w_done  = 1'b1;
            end else begin
              w_state = ST_PLAY;
              w_step  = w_rom_addr;
              w_cnt   = '0;
              w_dur   = w_entry.dur;
              w_freq  = w_entry.note;
              w_gate  = ~w_entry.rest;
              w_busy  = 1'b1;
              w_done  = w_last_step;
            end
          end else begin
            w_cnt = w_cnt_inc;
            if (w_cnt_inc >= w_gap_start) begin
              w_state = ST_GAP;
              w_gate  = 1'b0;
            end
          end
        end
        ST_DONE: begin
          w_state = ST_IDLE;
          w_gate  = 1'b0;
          w_busy  = 1'b0;
        end
        default: begin
          w_state = ST_IDLE;
          w_gate  = 1'b0;
          w_busy  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_step  <= 4'd0;
      r_cnt   <= '0;
      r_dur   <= 2'd0;
      r_freq  <= 3'd0;
      r_gate  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_step  <= w_step;
      r_cnt   <= w_cnt;
      r_dur   <= w_dur;
      r_freq  <= w_freq;
      r_gate  <= w_gate;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign freq = r_freq;
  assign gate = r_gate;
  assign busy = r_busy;
  assign done = r_done;

endmodule
